// File: rtl/keypad_replay.sv
// keypad_replay: replays queued key presses onto the active-low column lines of a 4x4 keypad scanner.
// Optional build macro KEYPAD_REPLAY_PASSTHRU_EN merges the physical column pins into keypadCol.
module keypad_replay #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned HOLD_SCANS = 4,
  parameter int unsigned GAP_SCANS  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [3:0] req_key,
  output logic       req_ready,
  input  logic [3:0] keypadRow,
`ifdef KEYPAD_REPLAY_PASSTHRU_EN
  input  logic [3:0] phys_col,
`endif
  output logic [3:0] keypadCol,
  output logic [3:0] active_key,
  output logic       busy
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned MAX_SCANS = (HOLD_SCANS > GAP_SCANS) ? HOLD_SCANS : GAP_SCANS;
  localparam int unsigned CW        = $clog2(MAX_SCANS + 1);

  typedef enum logic [1:0] {StIdle, StPress, StGap} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          prev_match_q;
  logic [3:0]    active_key_q;

  logic [3:0]    mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;

  logic       full, empty, push, pop;
  logic       match, scan_event;
  logic [3:0] replay_col;

  // Pointers carry an extra wrap bit to tell full from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign pop       = (state_q == StIdle) && !empty;

  // Only the exact one-hot-low strobe of the target row matches.
  assign match      = (keypadRow == ~(4'b0001 << active_key_q[3:2]));
  assign scan_event = prev_match_q && !match;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= req_key;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      prev_match_q <= 1'b0;
      active_key_q <= '0;
    end else begin
      prev_match_q <= match;
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            active_key_q <= mem_q[rd_ptr_q[AW-1:0]];
            cnt_q        <= '0;
            state_q      <= StPress;
          end
        end
        StPress: begin
          if (scan_event) begin
            if (cnt_q == CW'(HOLD_SCANS - 1)) begin
              cnt_q   <= '0;
              state_q <= StGap;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StGap: begin
          if (scan_event) begin
            if (cnt_q == CW'(GAP_SCANS - 1)) begin
              cnt_q   <= '0;
              state_q <= StIdle;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign replay_col = (state_q == StPress && match) ? ~(4'b0001 << active_key_q[1:0]) : 4'b1111;

`ifdef KEYPAD_REPLAY_PASSTHRU_EN
  assign keypadCol = replay_col & phys_col;
`else
  assign keypadCol = replay_col;
`endif

  assign active_key = active_key_q;
  assign busy       = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_keypad_replay.sv
// Scoreboard bench for keypad_replay: queued expected keys are matched against presses
// decoded from keypadRow/keypadCol by an independent monitor.
module tb_keypad_replay;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [3:0] req_key;
  logic       req_ready;
  logic [3:0] keypadRow;
  logic [3:0] keypadCol;
  logic [3:0] active_key;
  logic       busy;
`ifdef KEYPAD_REPLAY_PASSTHRU_EN
  logic [3:0] phys_col;
`endif

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];
  bit mon_en = 1'b1;

  keypad_replay #(.DEPTH(4), .HOLD_SCANS(4), .GAP_SCANS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_key    (req_key),
    .req_ready  (req_ready),
    .keypadRow  (keypadRow),
`ifdef KEYPAD_REPLAY_PASSTHRU_EN
    .phys_col   (phys_col),
`endif
    .keypadCol  (keypadCol),
    .active_key (active_key),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic bit one_low(input logic [3:0] v);
    return $countones(~v) == 1;
  endfunction

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (!v[i]) return i[1:0];
    return 2'd0;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [3:0] k);
    int n = 0;
    req_key   = k;
    req_valid = 1'b1;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout got=ready0 exp=ready1");
    end else begin
      exp_q.push_back(k);
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  // Cyclic row scan, 8-cycle strobes starting at row 0, until busy drops.
  task automatic scan_until_idle(input int max_strobes, output int n);
    logic [3:0] one = 4'b0001;
    n = 0;
    while (busy && n < max_strobes) begin
      for (int c = 0; c < 8; c++) begin
        keypadRow = ~(one << (n % 4));
        @(negedge clk);
      end
      n++;
    end
    keypadRow = 4'hF;
    check("drain_busy", {7'd0, busy}, 8'd0);
  endtask

  // Monitor: decodes each replayed press (consecutive pressed strobes of one key,
  // closed by an unpressed strobe of the same row) and compares against the queue.
  logic [3:0] last_row;
  bit         strobe_hit, in_press;
  logic [3:0] strobe_key, press_key, k;
  int         hits;
  logic [3:0] e;

  always @(posedge clk) begin
    #2;
    if (rst || !mon_en) begin
      strobe_hit = 0;
      in_press   = 0;
      hits       = 0;
      last_row   = keypadRow;
    end else begin
      if (keypadRow != last_row) begin
        if (one_low(last_row)) begin
          if (strobe_hit) begin
            if (in_press && strobe_key != press_key)
              check("press_change", {4'd0, strobe_key}, {4'd0, press_key});
            in_press  = 1;
            press_key = strobe_key;
            hits++;
          end else if (in_press && low_idx(last_row) == press_key[3:2]) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL press_unexpected got=%h exp=none", press_key);
            end else begin
              e = exp_q.pop_front();
              check("press_key", {4'd0, press_key}, {4'd0, e});
              check("press_hold", 8'(hits), 8'(HOLD));
            end
            in_press = 0;
            hits     = 0;
          end
        end
        strobe_hit = 0;
        last_row   = keypadRow;
      end
      if (keypadCol != 4'hF) begin
        if (!one_low(keypadRow) || !one_low(keypadCol)) begin
          check("col_shape", {keypadRow, keypadCol}, 8'hFF);
        end else begin
          k = {low_idx(keypadRow), low_idx(keypadCol)};
          if (strobe_hit && k != strobe_key)
            check("strobe_key", {4'd0, k}, {4'd0, strobe_key});
          strobe_hit = 1;
          strobe_key = k;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] one = 4'b0001;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_key   = 4'h0;
    keypadRow = 4'b1110;
`ifdef KEYPAD_REPLAY_PASSTHRU_EN
    phys_col  = 4'hF;
`endif
    repeat (2) @(negedge clk);
    check("reset_col", {4'd0, keypadCol}, 8'h0F);
    check("reset_ready", {7'd0, req_ready}, 8'd1);
    check("reset_busy", {7'd0, busy}, 8'd0);
    rst       = 1'b0;
    keypadRow = 4'hF;
    @(negedge clk);

    // Single key 6: 4 held row-1 strobes, 2 gap strobes, idle after strobe 22.
    push(4'h6);
    repeat (2) @(negedge clk);
    check("single_busy", {7'd0, busy}, 8'd1);
    scan_until_idle(400, n);
    check("single_strobes", 8'(n), 8'd23);

    // Invalid row patterns in PRESS with key 0 neither press nor count.
    push(4'h0);
    repeat (2) @(negedge clk);
    keypadRow = 4'b1100;
    repeat (3) @(negedge clk);
    check("inv_1100", {4'd0, keypadCol}, 8'h0F);
    keypadRow = 4'b1111;
    repeat (2) @(negedge clk);
    check("inv_1111", {4'd0, keypadCol}, 8'h0F);
    scan_until_idle(400, n);
    check("inv_strobes", 8'(n), 8'd22);

    // Full FIFO: first pops, next four fill, sixth is refused.
    push(4'h3);
    push(4'h9);
    push(4'h9);
    push(4'hC);
    push(4'h5);
    check("full_ready", {7'd0, req_ready}, 8'd0);
    req_key   = 4'hA;
    req_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("full_hold_ready", {7'd0, req_ready}, 8'd0);
    req_valid = 1'b0;
    check("full_busy", {7'd0, busy}, 8'd1);
    scan_until_idle(600, n);
    check("full_drained", 8'(exp_q.size()), 8'd0);

    // Reset on the second held strobe of key 4 with key 8 still queued.
    push(4'h4);
    push(4'h8);
    for (int s = 0; s < 6; s++) begin
      for (int c = 0; c < 8; c++) begin
        if (s == 5 && c == 3) check("rst_pre_col", {4'd0, keypadCol}, 8'h0E);
        keypadRow = ~(one << (s % 4));
        if (s == 5 && c == 3) begin
          rst = 1'b1;
          exp_q.delete();
        end
        @(negedge clk);
        if (s == 5 && c == 3) begin
          rst = 1'b0;
          check("rst_col", {4'd0, keypadCol}, 8'h0F);
          check("rst_busy", {7'd0, busy}, 8'd0);
          check("rst_ready", {7'd0, req_ready}, 8'd1);
        end
      end
    end
    check("rst_col_hold", {4'd0, keypadCol}, 8'h0F);
    keypadRow = 4'hF;
    repeat (2) @(negedge clk);
    check("rst_idle", {7'd0, busy}, 8'd0);
    check("end_queue", 8'(exp_q.size()), 8'd0);

`ifdef KEYPAD_REPLAY_PASSTHRU_EN
    mon_en   = 1'b0;
    phys_col = 4'b0111;
    @(negedge clk);
    check("pt_idle", {4'd0, keypadCol}, 8'h07);
    push(4'h0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    keypadRow = 4'b1110;
    @(negedge clk);
    check("pt_press", {4'd0, keypadCol}, 8'h06);
    keypadRow = 4'hF;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
